s3g_frame_rx: RTL

Parametrised S3G packet receiver with ping-pong payload buffering, CRC8 checking and an optional inter-byte timeout. It sits between `uart_transceiver` (`rx_data`/`rx_done`) and the S3G command executor. It frames `0xD5 | LEN | PAYLOAD[LEN] | CRC`, stores each payload in one of two banks, and presents each good packet to the executor through a ready/ack handshake. Errors are reported as one-cycle strobes.

---
 rtl/s3g_pkg.sv | 27 ++
 rtl/s3g_crc8.sv | 28 ++
 rtl/s3g_frame_rx.sv | 237 +++++++++++++++++++++++
 3 files changed

// File: rtl/s3g_pkg.sv
// s3g_pkg: constants and types shared by the S3G receiver, transmitter and executor.
//
// Contents:
//   S3G_SOF         start-of-frame byte
//   S3G_CRC_POLY    reflected Maxim/Dallas CRC8 polynomial
//   rx_state_e      receiver framing state
//   S3G_ERR_*       error codes reported by the executor
package s3g_pkg;

  localparam logic [7:0] S3G_SOF      = 8'hD5;
  localparam logic [7:0] S3G_CRC_POLY = 8'h8C;

  typedef enum logic [1:0] {
    StIdle,
    StLen,
    StPayload,
    StCrc
  } rx_state_e;

  // Error codes shared with s3g_executor.
  localparam logic [7:0] S3G_ERR_NONE    = 8'h00;
  localparam logic [7:0] S3G_ERR_CRC     = 8'h01;
  localparam logic [7:0] S3G_ERR_LEN     = 8'h02;
  localparam logic [7:0] S3G_ERR_OVERRUN = 8'h03;
  localparam logic [7:0] S3G_ERR_TIMEOUT = 8'h04;

endpackage

// File: rtl/s3g_crc8.sv
// s3g_crc8: combinational one-byte update of the Maxim/Dallas CRC8 (reflected, LSB first).
//
// Ports:
//   crc_in   [7:0] in   CRC accumulated so far
//   data     [7:0] in   byte to fold in
//   crc_out  [7:0] out  updated CRC
module s3g_crc8
  import s3g_pkg::*;
(
  input  logic [7:0] crc_in,
  input  logic [7:0] data,
  output logic [7:0] crc_out
);

  // Reflected form: XOR the whole byte in, then shift right eight times, folding the
  // polynomial back in whenever a one falls out of bit 0.
  always_comb begin
    crc_out = crc_in ^ data;
    for (int i = 0; i < 8; i++) begin
      if (crc_out[0]) begin
        crc_out = (crc_out >> 1) ^ S3G_CRC_POLY;
      end else begin
        crc_out = crc_out >> 1;
      end
    end
  end

endmodule

// File: rtl/s3g_frame_rx.sv
// s3g_frame_rx: S3G packet receiver with ping-pong payload banks and CRC8 checking.
//
// Frame format: 0xD5 | LEN | PAYLOAD[LEN] | CRC8(PAYLOAD). Good packets are stored in one of
// two banks and presented oldest-first through a ready/ack handshake. Errors are one-cycle
// strobes.
//
// Optional feature: define S3G_RX_TIMEOUT_EN to enable the inter-byte timeout. Without it
// timeout_err is tied low and a partial packet waits indefinitely.
//
// Parameters:
//   MAX_LEN         largest accepted payload length (1..255)
//   TIMEOUT_CYCLES  idle clocks allowed between bytes of one packet
//
// Ports:
//   clk          in   system clock
//   rst          in   synchronous active-high reset
//   rx_data      in   received byte, valid with rx_done
//   rx_done      in   one-cycle byte strobe
//   pkt_ready    out  a CRC-good packet is presented
//   pkt_len      out  payload length of the presented packet
//   pkt_ack      in   release the presented packet
//   rd_addr      in   payload byte index into the presented bank
//   rd_data      out  payload byte, one clock after rd_addr
//   crc          out  running CRC of the current payload
//   crc_err      out  strobe: CRC byte mismatch
//   len_err      out  strobe: LEN is 0 or above MAX_LEN
//   overrun_err  out  strobe: no free bank when LEN arrived
//   timeout_err  out  strobe: inter-byte timeout expired
module s3g_frame_rx
  import s3g_pkg::*;
#(
  parameter int unsigned MAX_LEN        = 32,
  parameter int unsigned TIMEOUT_CYCLES = 100000,
  localparam int unsigned AW            = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [7:0]    rx_data,
  input  logic          rx_done,
  output logic          pkt_ready,
  output logic [7:0]    pkt_len,
  input  logic          pkt_ack,
  input  logic [AW-1:0] rd_addr,
  output logic [7:0]    rd_data,
  output logic [7:0]    crc,
  output logic          crc_err,
  output logic          len_err,
  output logic          overrun_err,
  output logic          timeout_err
);

  localparam logic [7:0] MaxLen8 = 8'(MAX_LEN);

  rx_state_e       state_q, state_d;
  logic [7:0]      len_q, len_d;
  logic [7:0]      idx_q, idx_d;
  logic [7:0]      crc_q, crc_d;
  logic            wbank_q, wbank_d;
  logic [1:0]      full_q, full_d;
  logic            oldest_q, oldest_d;
  logic [1:0][7:0] blen_q, blen_d;
  logic            crc_err_q, crc_err_d;
  logic            len_err_q, len_err_d;
  logic            overrun_err_q, overrun_err_d;
  logic            timeout_err_q, timeout_err_d;
  logic [7:0]      rd_data_q;

  logic [7:0]      crc_next;
  logic            wr_en;
  logic [AW-1:0]   wr_addr;
  logic            ack_fire;
  logic            expire;

  logic [7:0]      mem0 [MAX_LEN];
  logic [7:0]      mem1 [MAX_LEN];

  s3g_crc8 u_crc8 (
    .crc_in  (crc_q),
    .data    (rx_data),
    .crc_out (crc_next)
  );

  // oldest_q always points at a full bank whenever at least one bank is full.
  assign pkt_ready = full_q[oldest_q];
  assign pkt_len   = pkt_ready ? blen_q[oldest_q] : 8'h00;
  assign ack_fire  = pkt_ack & pkt_ready;
  assign wr_addr   = idx_q[AW-1:0];

`ifdef S3G_RX_TIMEOUT_EN
  logic [31:0] idle_cnt_q;

  // An rx_done in the expiry cycle wins, so it is excluded here.
  assign expire = (state_q != StIdle) && !rx_done && (idle_cnt_q == TIMEOUT_CYCLES - 1);

  always_ff @(posedge clk) begin
    if (rst || rx_done || (state_q == StIdle)) begin
      idle_cnt_q <= 32'd0;
    end else begin
      idle_cnt_q <= idle_cnt_q + 32'd1;
    end
  end
`else
  logic unused_timeout;

  assign expire         = 1'b0;
  assign unused_timeout = ^TIMEOUT_CYCLES;
`endif

  always_comb begin
    state_d       = state_q;
    len_d         = len_q;
    idx_d         = idx_q;
    crc_d         = crc_q;
    wbank_d       = wbank_q;
    full_d        = full_q;
    oldest_d      = oldest_q;
    blen_d        = blen_q;
    crc_err_d     = 1'b0;
    len_err_d     = 1'b0;
    overrun_err_d = 1'b0;
    timeout_err_d = 1'b0;
    wr_en         = 1'b0;

    // The ack is applied before any completion in the same cycle.
    if (ack_fire) begin
      full_d[oldest_q] = 1'b0;
      oldest_d         = ~oldest_q;
    end

    if (expire) begin
      // The write bank is never marked full before the CRC byte, so it is already free.
      timeout_err_d = 1'b1;
      state_d       = StIdle;
    end else if (rx_done) begin
      unique case (state_q)
        StIdle: begin
          if (rx_data == S3G_SOF) begin
            state_d = StLen;
          end
        end
        StLen: begin
          state_d = StIdle;
          if ((rx_data == 8'h00) || (rx_data > MaxLen8)) begin
            len_err_d = 1'b1;
          end else if (&full_q) begin
            overrun_err_d = 1'b1;
          end else begin
            len_d   = rx_data;
            wbank_d = full_q[0];  // bank 0 unless it is occupied
            crc_d   = 8'h00;
            idx_d   = 8'h00;
            state_d = StPayload;
          end
        end
        StPayload: begin
          wr_en = 1'b1;
          crc_d = crc_next;
          idx_d = idx_q + 8'd1;
          if (idx_q == len_q - 8'd1) begin
            state_d = StCrc;
          end
        end
        StCrc: begin
          state_d = StIdle;
          if (rx_data == crc_q) begin
            full_d[wbank_q] = 1'b1;
            blen_d[wbank_q] = len_q;
            // Only becomes the presented bank when nothing older is still waiting.
            if (!full_d[~wbank_q]) begin
              oldest_d = wbank_q;
            end
          end else begin
            crc_err_d = 1'b1;
          end
        end
        default: state_d = StIdle;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= StIdle;
      len_q         <= 8'h00;
      idx_q         <= 8'h00;
      crc_q         <= 8'h00;
      wbank_q       <= 1'b0;
      full_q        <= 2'b00;
      oldest_q      <= 1'b0;
      blen_q        <= '0;
      crc_err_q     <= 1'b0;
      len_err_q     <= 1'b0;
      overrun_err_q <= 1'b0;
      timeout_err_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      len_q         <= len_d;
      idx_q         <= idx_d;
      crc_q         <= crc_d;
      wbank_q       <= wbank_d;
      full_q        <= full_d;
      oldest_q      <= oldest_d;
      blen_q        <= blen_d;
      crc_err_q     <= crc_err_d;
      len_err_q     <= len_err_d;
      overrun_err_q <= overrun_err_d;
      timeout_err_q <= timeout_err_d;
    end
  end

  // Payload storage carries no reset; validity is tracked by full_q.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      if (wbank_q) begin
        mem1[wr_addr] <= rx_data;
      end else begin
        mem0[wr_addr] <= rx_data;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_data_q <= 8'h00;
    end else begin
      rd_data_q <= oldest_q ? mem1[rd_addr] : mem0[rd_addr];
    end
  end

  assign rd_data     = rd_data_q;
  assign crc         = crc_q;
  assign crc_err     = crc_err_q;
  assign len_err     = len_err_q;
  assign overrun_err = overrun_err_q;
  assign timeout_err = timeout_err_q;

endmodule
